// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and hex-to-segment table for the 7-seg scanner.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int         NIB_W     = 4;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low codes, seg[0]=a .. seg[6]=g.
    function automatic logic [6:0] hex_to_seg(input logic [NIB_W-1:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_if
// Purpose  : Result-word input and display-pin bundle; bright exists only
//            when SEG7_DIM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_if
    import seg7_pkg::*;
#(
    parameter int NDIG = 4
);
    logic [NIB_W*NDIG-1:0] data;
    logic                  load;
    logic                  blank_lz;
    logic [NDIG-1:0]       dp_mask;
`ifdef SEG7_DIM_EN
    logic [3:0]            bright;
`endif
    logic [NDIG-1:0]       an;
    logic [6:0]            seg;
    logic                  dp;

`ifdef SEG7_DIM_EN
    modport master (output data, load, blank_lz, dp_mask, bright, input an, seg, dp);
    modport slave  (input data, load, blank_lz, dp_mask, bright, output an, seg, dp);
`else
    modport master (output data, load, blank_lz, dp_mask, input an, seg, dp);
    modport slave  (input data, load, blank_lz, dp_mask, output an, seg, dp);
`endif

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational nibble-to-segment decode with forced blank.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  wire logic [NIB_W-1:0] i_nib,
    input  wire logic             i_blank,
    output logic      [6:0]       o_seg
);

    assign o_seg = i_blank ? SEG_BLANK : hex_to_seg(i_nib);

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Purpose  : Multiplexed common-anode hex display driver with shadow register,
//            anti-ghost blanking and leading-zero suppression. Optional PWM
//            dimming via SEG7_DIM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 500
)(
    input  wire logic  clk,
    input  wire logic  rst,
    seg7_scan_if.slave bus
);

    localparam int             c_CW    = $clog2(DIV);
    localparam int             c_IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(DIV - 1);
    localparam logic [c_CW-1:0] c_BLANK = c_CW'(BLANK_CYC);
    localparam logic [c_IW-1:0] c_ILAST = c_IW'(NDIG - 1);

    logic [NIB_W*NDIG-1:0] r_shadow;
    logic [c_CW-1:0]       r_cnt;
    logic [c_IW-1:0]       r_idx;
    logic [NDIG-1:0]       r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic [NDIG-1:0]       w_blank;
    logic [NDIG-1:0]       w_an_sel;
    logic [NIB_W-1:0]      w_nib;
    logic                  w_lz;
    logic                  w_dp;
    logic                  w_lit;
    logic [6:0]            w_seg;

    // A digit blanks when it and every more-significant nibble are zero.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_lz
        if (gi == 0) begin : g_d0
            assign w_blank[gi] = 1'b0;
        end else begin : g_dn
            assign w_blank[gi] = bus.blank_lz & ~(|r_shadow[NIB_W*NDIG-1 : gi*NIB_W]);
        end
    end

    always_comb begin
        w_nib    = '0;
        w_lz     = 1'b0;
        w_dp     = 1'b1;
        w_an_sel = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_nib       = r_shadow[i*NIB_W +: NIB_W];
                w_lz        = w_blank[i];
                w_dp        = ~bus.dp_mask[i];
                w_an_sel[i] = 1'b0;
            end
        end
    end

`ifdef SEG7_DIM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pwm <= '0;
        else     r_pwm <= r_pwm + 4'd1;
    end

    assign w_lit = (r_cnt >= c_BLANK) && (r_pwm < bus.bright);
`else
    assign w_lit = (r_cnt >= c_BLANK);
`endif

    seg7_decode u_dec (
        .i_nib   (w_nib),
        .i_blank (w_lz),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_an     <= '1;
            r_seg    <= SEG_BLANK;
            r_dp     <= 1'b1;
        end else begin
            if (bus.load) r_shadow <= bus.data;
            if (r_cnt == c_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_ILAST) ? '0 : r_idx + c_IW'(1);
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end
            r_an  <= w_lit ? w_an_sel : '1;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Directed self-checking bench for seg7_scan (NDIG=4, DIV=4, BLANK_CYC=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan;

    localparam int NDIG      = 4;
    localparam int DIV       = 4;
    localparam int BLANK_CYC = 1;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   n        = 0;
    logic [6:0] exp_seg [NDIG];
    logic [6:0] old_seg;
    int   slot_a;

    seg7_scan_if #(.NDIG(NDIG)) bus ();

    seg7_scan #(.NDIG(NDIG), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    function automatic int slot_of(input int e);
        return ((e - 1) / DIV) % NDIG;
    endfunction

    function automatic logic [3:0] exp_an(input int e);
        logic [3:0] one;
        if (((e - 1) % DIV) < BLANK_CYC) return 4'hF;
`ifdef SEG7_DIM_EN
        if (((e - 1) % 16) >= int'(bus.bright)) return 4'hF;
`endif
        one = 4'b0001 << slot_of(e);
        return ~one;
    endfunction

    task automatic tick();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    // Checks an and dp every edge; seg against exp_seg when chk_seg is set.
    task automatic scan(input int cycles, input bit chk_seg);
        for (int k = 0; k < cycles; k++) begin
            tick();
            chk("an", {3'b0, bus.an}, {3'b0, exp_an(n)});
            chk("dp", {6'b0, bus.dp}, {6'b0, ~bus.dp_mask[slot_of(n)]});
            if (chk_seg) chk($sformatf("seg_d%0d", slot_of(n)), bus.seg, exp_seg[slot_of(n)]);
        end
    endtask

    task automatic set_exp(input logic [6:0] s0, s1, s2, s3);
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    endtask

    initial begin
        rst          = 1'b1;
        bus.data     = 16'h0000;
        bus.load     = 1'b1;
        bus.blank_lz = 1'b0;
        bus.dp_mask  = 4'b0000;
`ifdef SEG7_DIM_EN
        bus.bright   = 4'd15;
`endif
        repeat (2) @(negedge clk);
        chk("rst_an",  {3'b0, bus.an}, 7'h0F);
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_dp",  {6'b0, bus.dp}, 7'h01);
        rst = 1'b0;
        n   = 0;

        // Zero word, no blanking: every digit shows "0"
        set_exp(7'h40, 7'h40, 7'h40, 7'h40);
        scan(1, 1'b0);
        scan(16, 1'b1);

        bus.data = 16'h12AB;
        scan(2, 1'b0);
        set_exp(7'h03, 7'h08, 7'h24, 7'h79);
        scan(16, 1'b1);

        bus.blank_lz = 1'b1;
        bus.data     = 16'h0005;
        scan(2, 1'b0);
        set_exp(7'h12, 7'h7F, 7'h7F, 7'h7F);
        scan(16, 1'b1);

        bus.data = 16'h0000;
        scan(2, 1'b0);
        set_exp(7'h40, 7'h7F, 7'h7F, 7'h7F);
        scan(16, 1'b1);

        bus.data = 16'h0105;
        scan(2, 1'b0);
        set_exp(7'h12, 7'h40, 7'h79, 7'h7F);
        scan(16, 1'b1);

        // Hold: shadow ignores data while load is low
        bus.blank_lz = 1'b0;
        bus.data     = 16'h00AB;
        scan(2, 1'b0);
        set_exp(7'h03, 7'h08, 7'h40, 7'h40);
        scan(16, 1'b1);
        bus.load = 1'b0;
        bus.data = 16'hFFFF;
        scan(16, 1'b1);

        // Single-cycle load pulse: F appears two edges later
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        slot_a   = slot_of(n);
        old_seg  = exp_seg[slot_a];
        chk("pulse_edge1", bus.seg, old_seg);
        tick();
        chk("pulse_edge2", bus.seg, 7'h0E);
        set_exp(7'h0E, 7'h0E, 7'h0E, 7'h0E);
        scan(16, 1'b1);

        // Decimal point follows the scanned digit
        bus.dp_mask = 4'b0100;
        scan(1, 1'b0);
        scan(16, 1'b1);
        bus.dp_mask = 4'b0000;

`ifdef SEG7_DIM_EN
        bus.bright = 4'd0;
        scan(32, 1'b1);
        bus.bright = 4'd15;
`endif

        // Asynchronous reset mid-scan, no clock edge needed
        #2;
        rst = 1'b1;
        #1;
        chk("arst_an",  {3'b0, bus.an}, 7'h0F);
        chk("arst_seg", bus.seg, 7'h7F);
        chk("arst_dp",  {6'b0, bus.dp}, 7'h01);
        @(negedge clk);
        bus.load = 1'b1;
        bus.data = 16'h12AB;
        rst      = 1'b0;
        n        = 0;
        tick();
        chk("post_rst_an1", {3'b0, bus.an}, 7'h0F);
        tick();
        chk("post_rst_an2", {3'b0, bus.an}, 7'h0E);
        set_exp(7'h03, 7'h08, 7'h24, 7'h79);
        scan(16, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
